pid_stage_sequencer: RTL and testbench

- Timing/control unit for the PID datapath: generates the sample tick and handshakes the ADC.
- Fires the one-cycle stage enables etapa1..etapa5 that clock the integral/proportional registers in order.
- One sequencer serves the whole controller; it is the only source of etapa strobes.
- Guards the integrator against half-updates: overrun, ADC timeout and disable never split an etapa2/etapa5 pair.

---
 rtl/pid_stage_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_pid_stage_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_stage_sequencer.sv
// pid_stage_sequencer: sample timer, ADC handshake and ordered etapa1..etapa5 strobes for the PID datapath.
// Optional build macro SEQ_INTEG_HOLD_EN adds a hold input that freezes the integrator (etapa2/etapa5) per sequence.
module pid_stage_sequencer #(
  parameter int unsigned SAMPLE_DIV  = 1000,
  parameter int unsigned ADC_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        adc_ack,
  input  logic        clr_err,
`ifdef SEQ_INTEG_HOLD_EN
  input  logic        hold,
`endif
  output logic        adc_req,
  output logic        etapa1,
  output logic        etapa2,
  output logic        etapa3,
  output logic        etapa4,
  output logic        etapa5,
  output logic        busy,
  output logic        ciclo_listo,
  output logic        overrun,
  output logic        timeout_err,
  output logic [15:0] n_muestras
);

  localparam int unsigned TIMER_W = 16;
  localparam int unsigned WAIT_W  = 8;
  localparam int unsigned CNT_W   = 16;

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SAMPLE_DIV - 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(ADC_TIMEOUT - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADC_WAIT = 3'd1;
  localparam logic [2:0] S_E1       = 3'd2;
  localparam logic [2:0] S_E2       = 3'd3;
  localparam logic [2:0] S_E3       = 3'd4;
  localparam logic [2:0] S_E4       = 3'd5;
  localparam logic [2:0] S_E5       = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  logic [2:0]         state;
  logic [2:0]         state_nxt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [WAIT_W-1:0]  wait_nxt;
  logic [TIMER_W-1:0] timer;
  logic               tick_c;
  logic               freeze_e2_c;
  logic               freeze_e5_c;

  logic               adc_req_nxt;
  logic               etapa1_nxt;
  logic               etapa2_nxt;
  logic               etapa3_nxt;
  logic               etapa4_nxt;
  logic               etapa5_nxt;
  logic               busy_nxt;
  logic               ciclo_listo_nxt;
  logic               overrun_nxt;
  logic               timeout_err_nxt;
  logic [CNT_W-1:0]   n_muestras_nxt;
  logic               timeout_set_c;
  logic               overrun_set_c;

  // Free-running sample timer; held at zero while disabled so no tick can fire.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer <= '0;
    end else if (!enable) begin
      timer <= '0;
    end else if (timer == TIMER_LAST) begin
      timer <= '0;
    end else begin
      timer <= timer + TIMER_W'(1);
    end
  end

  assign tick_c = enable && (timer == TIMER_LAST);

`ifdef SEQ_INTEG_HOLD_EN
  logic hold_q;

  // hold is captured while in E1; etapa2 uses the live value (leaving E1), etapa5 the stored one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= 1'b0;
    end else if (state == S_E1) begin
      hold_q <= hold;
    end
  end

  assign freeze_e2_c = hold;
  assign freeze_e5_c = hold_q;
`else
  assign freeze_e2_c = 1'b0;
  assign freeze_e5_c = 1'b0;
`endif

  // Next-state, wait counter and next registered outputs.
  always_comb begin
    state_nxt     = state;
    wait_nxt      = wait_cnt;
    timeout_set_c = 1'b0;
    overrun_set_c = tick_c && (state != S_IDLE);

    case (state)
      S_IDLE: begin
        wait_nxt = '0;
        if (tick_c) begin
          state_nxt = S_ADC_WAIT;
        end
      end
      S_ADC_WAIT: begin
        // An ack on the final allowed cycle still wins over the timeout.
        if (adc_ack) begin
          state_nxt = S_E1;
          wait_nxt  = '0;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt     = S_IDLE;
          wait_nxt      = '0;
          timeout_set_c = 1'b1;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      S_E1:    state_nxt = S_E2;
      S_E2:    state_nxt = S_E3;
      S_E3:    state_nxt = S_E4;
      S_E4:    state_nxt = S_E5;
      S_E5:    state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    adc_req_nxt     = (state_nxt == S_ADC_WAIT);
    etapa1_nxt      = (state_nxt == S_E1);
    etapa2_nxt      = (state_nxt == S_E2) && !freeze_e2_c;
    etapa3_nxt      = (state_nxt == S_E3);
    etapa4_nxt      = (state_nxt == S_E4);
    etapa5_nxt      = (state_nxt == S_E5) && !freeze_e5_c;
    busy_nxt        = (state_nxt != S_IDLE);
    ciclo_listo_nxt = (state_nxt == S_DONE);

    n_muestras_nxt = n_muestras;
    if (state_nxt == S_DONE) begin
      n_muestras_nxt = n_muestras + CNT_W'(1);
    end

    // Sticky flags: a set event in the same cycle as clr_err takes priority.
    overrun_nxt = overrun;
    if (overrun_set_c) begin
      overrun_nxt = 1'b1;
    end else if (clr_err) begin
      overrun_nxt = 1'b0;
    end

    timeout_err_nxt = timeout_err;
    if (timeout_set_c) begin
      timeout_err_nxt = 1'b1;
    end else if (clr_err) begin
      timeout_err_nxt = 1'b0;
    end
  end

  // State register and registered Moore outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      adc_req     <= 1'b0;
      etapa1      <= 1'b0;
      etapa2      <= 1'b0;
      etapa3      <= 1'b0;
      etapa4      <= 1'b0;
      etapa5      <= 1'b0;
      busy        <= 1'b0;
      ciclo_listo <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      n_muestras  <= '0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_nxt;
      adc_req     <= adc_req_nxt;
      etapa1      <= etapa1_nxt;
      etapa2      <= etapa2_nxt;
      etapa3      <= etapa3_nxt;
      etapa4      <= etapa4_nxt;
      etapa5      <= etapa5_nxt;
      busy        <= busy_nxt;
      ciclo_listo <= ciclo_listo_nxt;
      overrun     <= overrun_nxt;
      timeout_err <= timeout_err_nxt;
      n_muestras  <= n_muestras_nxt;
    end
  end

endmodule

// File: tb/tb_pid_stage_sequencer.sv
// Scoreboard bench for pid_stage_sequencer: expected output events are queued by cycle, a monitor pops and compares.
// With SEQ_INTEG_HOLD_EN defined the first sequence runs with hold=1 and expects no etapa2/etapa5.
module tb_pid_stage_sequencer;

  localparam int unsigned SDIV = 12;
  localparam int unsigned TOUT = 8;

  // Event bit positions in the monitor vector.
  localparam logic [8:0] EV_REQ = 9'h001;
  localparam logic [8:0] EV_E1  = 9'h002;
  localparam logic [8:0] EV_E2  = 9'h004;
  localparam logic [8:0] EV_E3  = 9'h008;
  localparam logic [8:0] EV_E4  = 9'h010;
  localparam logic [8:0] EV_E5  = 9'h020;
  localparam logic [8:0] EV_CL  = 9'h040;
  localparam logic [8:0] EV_TO  = 9'h080;
  localparam logic [8:0] EV_OV  = 9'h100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        adc_ack;
  logic        clr_err = 1'b0;
  logic        adc_req, etapa1, etapa2, etapa3, etapa4, etapa5;
  logic        busy, ciclo_listo, overrun, timeout_err;
  logic [15:0] n_muestras;
`ifdef SEQ_INTEG_HOLD_EN
  logic        hold = 1'b0;
  localparam bit SEQ1_INTEG = 1'b0;
`else
  localparam bit SEQ1_INTEG = 1'b1;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  pid_stage_sequencer #(.SAMPLE_DIV(SDIV), .ADC_TIMEOUT(TOUT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .adc_ack(adc_ack), .clr_err(clr_err),
`ifdef SEQ_INTEG_HOLD_EN
    .hold(hold),
`endif
    .adc_req(adc_req), .etapa1(etapa1), .etapa2(etapa2), .etapa3(etapa3),
    .etapa4(etapa4), .etapa5(etapa5), .busy(busy), .ciclo_listo(ciclo_listo),
    .overrun(overrun), .timeout_err(timeout_err), .n_muestras(n_muestras)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: acks on the ack_delay-th cycle that adc_req is seen high (0 = never acks).
  int   ack_delay = 1;
  int   req_seen = 0;
  logic resp_ack = 1'b0;
  logic stray_ack = 1'b0;
  always @(negedge clk) begin
    if (adc_req) begin
      req_seen = req_seen + 1;
      resp_ack = (ack_delay != 0) && (req_seen == ack_delay);
    end else begin
      req_seen = 0;
      resp_ack = 1'b0;
    end
  end
  assign adc_ack = resp_ack | stray_ack;

  typedef struct {
    int         cyc;
    logic [8:0] ev;
    int         nm;
  } exp_t;

  exp_t sbq[$];

  // Insert an expected event sorted by cycle, merging events that share a cycle.
  task automatic push_ev(input int c, input logic [8:0] v, input int nm);
    int   i;
    exp_t e;
    i = 0;
    while (i < sbq.size() && sbq[i].cyc < c) i++;
    if (i < sbq.size() && sbq[i].cyc == c) begin
      e = sbq[i];
      e.ev = e.ev | v;
      if (nm >= 0) e.nm = nm;
      sbq[i] = e;
    end else begin
      e.cyc = c;
      e.ev  = v;
      e.nm  = nm;
      sbq.insert(i, e);
    end
  endtask

  // One full sequence from a tick in cycle t with ack on the k-th adc_req cycle.
  task automatic expect_seq(input int t, input int k, input int nm, input bit integ);
    push_ev(t + 1, EV_REQ, -1);
    push_ev(t + k + 1, EV_E1, -1);
    if (integ) push_ev(t + k + 2, EV_E2, -1);
    push_ev(t + k + 3, EV_E3, -1);
    push_ev(t + k + 4, EV_E4, -1);
    if (integ) push_ev(t + k + 5, EV_E5, -1);
    push_ev(t + k + 6, EV_CL, nm);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor: any edge-of-interest on the outputs must match the queued expectation for this cycle.
  logic p_req = 1'b0, p_to = 1'b0, p_ov = 1'b0;
  always @(negedge clk) begin : monitor
    logic [8:0] ev;
    exp_t       e;
    bit         have;
    ev = {overrun & ~p_ov, timeout_err & ~p_to, ciclo_listo, etapa5, etapa4,
          etapa3, etapa2, etapa1, adc_req & ~p_req};
    p_req = adc_req;
    p_to  = timeout_err;
    p_ov  = overrun;
    have  = 1'b0;
    e.cyc = 0;
    e.ev  = '0;
    e.nm  = -1;
    if (sbq.size() > 0) begin
      if (sbq[0].cyc <= cyc) begin
        e    = sbq.pop_front();
        have = 1'b1;
      end
    end
    if (have || ev != 9'h000) begin
      n_cmp++;
      if (!have) begin
        n_err++;
        $display("FAIL event: cycle %0d got events %h, required none", cyc, ev);
      end else if (e.cyc != cyc || e.ev != ev) begin
        n_err++;
        $display("FAIL event: cycle %0d got events %h, required %h at cycle %0d", cyc, ev, e.ev, e.cyc);
      end else if (e.nm >= 0) begin
        n_cmp++;
        if (n_muestras !== 16'(e.nm)) begin
          n_err++;
          $display("FAIL n_muestras: cycle %0d got %0d, required %0d", cyc, n_muestras, e.nm);
        end
      end
    end
  end

  initial begin
    // Asynchronous reset before any clock edge.
    #1 rst = 1'b0;
    #1 check("reset_outputs",
             {6'd0, adc_req, etapa1, etapa2, etapa3, etapa4, etapa5, busy, ciclo_listo,
              overrun, timeout_err, n_muestras}, 32'd0);

    // Enable with timer at 0 in cycle 4: ticks at 15, 27, 39, ...
    wait_cyc(4);
    rst    = 1'b1;
    enable = 1'b1;
`ifdef SEQ_INTEG_HOLD_EN
    hold = 1'b1;
`endif
    expect_seq(15, 1, 1, SEQ1_INTEG);

    wait_cyc(24);
`ifdef SEQ_INTEG_HOLD_EN
    hold = 1'b0;
`endif
    ack_delay = 3;
    expect_seq(27, 3, 2, 1'b1);

    // Withheld ack: adc_req for TOUT cycles, then timeout with no strobes.
    wait_cyc(37);
    ack_delay = 0;
    push_ev(40, EV_REQ, -1);
    push_ev(48, EV_TO, -1);

    wait_cyc(49);
    check("timeout_sticky", 32'(timeout_err), 32'd1);
    check("timeout_count_held", 32'(n_muestras), 32'd2);
    stray_ack = 1'b1;
    ack_delay = 8;
    wait_cyc(50);
    clr_err = 1'b1;
    wait_cyc(51);
    clr_err   = 1'b0;
    stray_ack = 1'b0;
    check("timeout_clear", 32'(timeout_err), 32'd0);

    // Ack on the last allowed cycle wins; the late finish makes tick 63 an overrun.
    expect_seq(51, 8, 3, 1'b1);
    push_ev(64, EV_OV, -1);

    wait_cyc(66);
    check("overrun_sticky", 32'(overrun), 32'd1);
    ack_delay = 1;
    expect_seq(75, 1, 4, 1'b1);
    wait_cyc(70);
    clr_err = 1'b1;
    wait_cyc(71);
    clr_err = 1'b0;
    check("overrun_clear", 32'(overrun), 32'd0);

    // Overrun coinciding with clr_err: set wins.
    wait_cyc(84);
    ack_delay = 8;
    expect_seq(87, 8, 5, 1'b1);
    push_ev(100, EV_OV, -1);
    wait_cyc(99);
    clr_err = 1'b1;
    wait_cyc(100);
    clr_err = 1'b0;
    check("overrun_set_wins", 32'(overrun), 32'd1);
    wait_cyc(103);
    clr_err = 1'b1;
    wait_cyc(104);
    clr_err = 1'b0;
    check("overrun_clear2", 32'(overrun), 32'd0);

    // enable dropped during ADC_WAIT: sequence completes, no further requests.
    wait_cyc(108);
    ack_delay = 3;
    expect_seq(111, 3, 6, 1'b1);
    wait_cyc(113);
    enable = 1'b0;
    wait_cyc(121);
    check("idle_after_disable", 32'(busy), 32'd0);
    check("count_after_disable", 32'(n_muestras), 32'd6);

    // Re-enable, then reset asynchronously while in E3.
    wait_cyc(140);
    enable    = 1'b1;
    ack_delay = 1;
    push_ev(152, EV_REQ, -1);
    push_ev(153, EV_E1, -1);
    push_ev(154, EV_E2, -1);
    push_ev(155, EV_E3, -1);
    wait_cyc(155);
    #2;
    rst    = 1'b0;
    enable = 1'b0;
    #1 check("async_reset_outputs",
             {6'd0, adc_req, etapa1, etapa2, etapa3, etapa4, etapa5, busy, ciclo_listo,
              overrun, timeout_err, n_muestras}, 32'd0);
    wait_cyc(157);
    rst = 1'b1;

    wait_cyc(175);
    check("count_after_reset", 32'(n_muestras), 32'd0);
    check("idle_after_reset", 32'(busy), 32'd0);
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
